// File: rtl/lc3b_types.sv
// Shared LC-3b cache types: L1 address fields, way select and line width.
package lc3b_types;

    localparam int unsigned L1_OFFSET_BITS = 5;

    typedef logic [2:0]   lc3b_l1_index;
    typedef logic [7:0]   lc3b_l1_tag;
    typedef logic [1:0]   lc3b_l1_way;
    typedef logic [255:0] lc3b_c_line;
    typedef logic [15:0]  lc3b_word;

    // Line-aligned byte address from a tag/index pair.
    function automatic lc3b_word line_addr(input lc3b_l1_tag tag, input lc3b_l1_index index);
        return {tag, index, {L1_OFFSET_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/l1_evict_ctrl_victim_select.sv
// Victim way choice for a miss. Optional L1_INVALID_FIRST_EN prefers the lowest invalid way.
module victim_select
    import lc3b_types::*;
(
    input  logic [3:0] valid_vec,
    input  logic [1:0] lru_way,
    output logic [1:0] victim_way
);

    lc3b_l1_way w_way;

`ifdef L1_INVALID_FIRST_EN
    // Scan high to low so the lowest-numbered invalid way wins.
    always_comb begin
        w_way = lru_way;
        for (int i = 3; i >= 0; i--) begin
            if (!valid_vec[i]) begin
                w_way = 2'(i);
            end
        end
    end
`else
    logic w_unused_valid;

    assign w_unused_valid = ^valid_vec;
    assign w_way          = lru_way;
`endif

    assign victim_way = w_way;

endmodule

// File: rtl/l1_evict_ctrl.sv
// L1 miss service: victim select, optional writeback, line fill, install and LRU update.
// Victim policy is switched by L1_INVALID_FIRST_EN inside victim_select.
module l1_evict_ctrl
    import lc3b_types::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         miss_req,
    input  logic [15:0]  miss_addr,
    input  logic [1:0]   lru_way,
    input  logic [3:0]   valid_vec,
    input  logic [3:0]   dirty_vec,
    input  logic [7:0]   victim_tag,
    input  logic [255:0] victim_data,
    output logic [1:0]   sel_way,
    output logic         mem_read,
    output logic         mem_write,
    output logic [15:0]  mem_address,
    output logic [255:0] mem_wdata,
    input  logic         mem_resp,
    input  logic [255:0] mem_rdata,
    output logic         fill_we,
    output logic [2:0]   fill_index,
    output logic [7:0]   fill_tag,
    output logic [255:0] fill_data,
    output logic         lru_load,
    output logic         evict_done,
    output logic         busy
);

    typedef enum logic [2:0] {
        StIdle,
        StSelect,
        StWriteback,
        StFill,
        StInstall
    } state_e;

    state_e       r_state;
    state_e       w_state_next;
    lc3b_l1_tag   r_addr_tag;
    lc3b_l1_index r_addr_index;
    lc3b_l1_way   r_way;
    lc3b_l1_tag   r_tag;
    lc3b_c_line   r_data;
    lc3b_c_line   r_fill;
    lc3b_l1_way   w_victim_way;
    logic         w_victim_dirty;

    victim_select u_victim_select (
        .valid_vec  (valid_vec),
        .lru_way    (lru_way),
        .victim_way (w_victim_way)
    );

    // An invalid way never holds modified data, whatever its dirty bit says.
    assign w_victim_dirty = valid_vec[w_victim_way] & dirty_vec[w_victim_way];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_addr_tag   <= '0;
            r_addr_index <= '0;
            r_way        <= '0;
            r_tag        <= '0;
            r_data       <= '0;
            r_fill       <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == StIdle && miss_req) begin
                r_addr_tag   <= miss_addr[15:8];
                r_addr_index <= miss_addr[7:5];
            end
            if (r_state == StSelect) begin
                r_way  <= w_victim_way;
                r_tag  <= victim_tag;
                r_data <= victim_data;
            end
            if (r_state == StFill && mem_resp) begin
                r_fill <= mem_rdata;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        sel_way      = '0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_address  = '0;
        mem_wdata    = '0;
        fill_we      = 1'b0;
        fill_index   = '0;
        fill_tag     = '0;
        fill_data    = '0;
        lru_load     = 1'b0;
        evict_done   = 1'b0;
        busy         = (r_state != StIdle);

        unique case (r_state)
            StIdle: begin
                if (miss_req) begin
                    w_state_next = StSelect;
                end
            end
            StSelect: begin
                // Arrays see the victim this cycle so its tag/data can be captured.
                sel_way      = w_victim_way;
                w_state_next = w_victim_dirty ? StWriteback : StFill;
            end
            StWriteback: begin
                sel_way     = r_way;
                mem_write   = 1'b1;
                mem_address = line_addr(r_tag, r_addr_index);
                mem_wdata   = r_data;
                if (mem_resp) begin
                    w_state_next = StFill;
                end
            end
            StFill: begin
                sel_way     = r_way;
                mem_read    = 1'b1;
                mem_address = line_addr(r_addr_tag, r_addr_index);
                if (mem_resp) begin
                    w_state_next = StInstall;
                end
            end
            StInstall: begin
                sel_way      = r_way;
                fill_we      = 1'b1;
                lru_load     = 1'b1;
                evict_done   = 1'b1;
                fill_index   = r_addr_index;
                fill_tag     = r_addr_tag;
                fill_data    = r_fill;
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_l1_evict_ctrl.sv
// Directed bench for l1_evict_ctrl with a behavioural tag/data array and memory responder.
module tb_l1_evict_ctrl;

    logic         clk;
    logic         rst_n;
    logic         miss_req;
    logic [15:0]  miss_addr;
    logic [1:0]   lru_way;
    logic [3:0]   valid_vec;
    logic [3:0]   dirty_vec;
    logic [7:0]   victim_tag;
    logic [255:0] victim_data;
    logic [1:0]   sel_way;
    logic         mem_read;
    logic         mem_write;
    logic [15:0]  mem_address;
    logic [255:0] mem_wdata;
    logic         mem_resp;
    logic [255:0] mem_rdata;
    logic         fill_we;
    logic [2:0]   fill_index;
    logic [7:0]   fill_tag;
    logic [255:0] fill_data;
    logic         lru_load;
    logic         evict_done;
    logic         busy;

    logic [7:0]   tags  [4];
    logic [255:0] datas [4];

    int n_tests = 0;
    int n_fail  = 0;
    int evict_cnt = 0;
    int fill_cnt  = 0;
    bit both_seen = 0;

    bit           res_done;
    int           res_cycles;
    int           res_wr_cnt;
    int           res_rd_cnt;
    logic [15:0]  res_wr_addr;
    logic [255:0] res_wr_data;
    logic [15:0]  res_rd_addr;
    logic         res_fill_we;
    logic         res_lru;
    logic [1:0]   res_way;
    logic [2:0]   res_idx;
    logic [7:0]   res_tag;
    logic [255:0] res_data;

    l1_evict_ctrl u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .miss_req    (miss_req),
        .miss_addr   (miss_addr),
        .lru_way     (lru_way),
        .valid_vec   (valid_vec),
        .dirty_vec   (dirty_vec),
        .victim_tag  (victim_tag),
        .victim_data (victim_data),
        .sel_way     (sel_way),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_resp    (mem_resp),
        .mem_rdata   (mem_rdata),
        .fill_we     (fill_we),
        .fill_index  (fill_index),
        .fill_tag    (fill_tag),
        .fill_data   (fill_data),
        .lru_load    (lru_load),
        .evict_done  (evict_done),
        .busy        (busy)
    );

    assign victim_tag  = tags[sel_way];
    assign victim_data = datas[sel_way];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (evict_done) evict_cnt++;
        if (fill_we) fill_cnt++;
        if (mem_read && mem_write) both_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One miss from IDLE; the memory answers on the dly-th cycle of each request.
    task automatic run_miss(input logic [15:0] addr, input logic [1:0] lru, input logic [3:0] v,
                            input logic [3:0] d, input int dly, input logic [255:0] rdata,
                            input bit resp_sel, input bit toggle);
        int wr_run = 0;
        int rd_run = 0;
        res_done = 0; res_cycles = 0; res_wr_cnt = 0; res_rd_cnt = 0;
        res_wr_addr = '0; res_wr_data = '0; res_rd_addr = '0; res_fill_we = 0; res_lru = 0;
        res_way = '0; res_idx = '0; res_tag = '0; res_data = '0;
        @(negedge clk);
        miss_addr = addr; lru_way = lru; valid_vec = v; dirty_vec = d; mem_rdata = rdata;
        miss_req = 1'b1;
        for (int n = 1; n <= 40 && !res_done; n++) begin
            @(negedge clk);
            mem_resp = 1'b0;
            if (n == 1 && resp_sel) mem_resp = 1'b1;
            if (mem_write) begin
                res_wr_cnt++; wr_run++;
                res_wr_addr = mem_address; res_wr_data = mem_wdata;
                if (wr_run == dly) mem_resp = 1'b1;
            end
            if (mem_read) begin
                res_rd_cnt++; rd_run++;
                res_rd_addr = mem_address;
                if (rd_run == dly) mem_resp = 1'b1;
                if (toggle) miss_req = ~miss_req;
            end
            if (evict_done) begin
                res_done = 1; res_cycles = n;
                res_fill_we = fill_we; res_lru = lru_load; res_way = sel_way;
                res_idx = fill_index; res_tag = fill_tag; res_data = fill_data;
                miss_req = 1'b0;
            end
        end
        mem_resp = 1'b0;
        miss_req = 1'b0;
        check("miss_completed", res_done, 1);
    endtask

    logic [255:0] line_a, line_b, line_c, line_d;
    int evict_before, fill_before, cyc;
    int t_done [3];
    int n_done;
    bit saw_wb;

    initial begin
        line_a = {8{32'hA5A5_0001}};
        line_b = {8{32'h0BB0_0002}};
        line_c = {8{32'hC0DE_0003}};
        line_d = {8{32'hD00D_0004}};
        tags[0] = 8'hA0; tags[1] = 8'h7F; tags[2] = 8'h5C; tags[3] = 8'hBE;
        for (int i = 0; i < 4; i++) datas[i] = {8{24'hDA7A00, 8'(i)}};
        rst_n = 1'b1; miss_req = 0; miss_addr = '0; lru_way = '0; valid_vec = '0;
        dirty_vec = '0; mem_resp = 0; mem_rdata = '0;

        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_mem_read", mem_read, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_fill_we", fill_we, 0);
        check("rst_lru_load", lru_load, 0);
        check("rst_evict_done", evict_done, 0);
        check("rst_sel_way", sel_way, 0);
        check("rst_mem_address", mem_address, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_fill_index", fill_index, 0);
        check("rst_fill_tag", fill_tag, 0);
        check("rst_fill_data", fill_data, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Clean miss, late response.
        run_miss(16'h12A0, 2'd2, 4'b1111, 4'b0000, 3, line_a, 0, 0);
        check("clean_cycles", res_cycles, 5);
        check("clean_no_write", res_wr_cnt, 0);
        check("clean_read_cycles", res_rd_cnt, 3);
        check("clean_read_addr", res_rd_addr, 16'h12A0);
        check("clean_fill_we", res_fill_we, 1);
        check("clean_lru_load", res_lru, 1);
        check("clean_way", res_way, 2);
        check("clean_index", res_idx, 5);
        check("clean_tag", res_tag, 8'h12);
        check("clean_data", res_data, line_a);

        // Dirty miss, immediate responses.
        run_miss(16'h3440, 2'd1, 4'b1111, 4'b0010, 1, line_b, 0, 0);
        check("dirty_cycles", res_cycles, 4);
        check("dirty_write_cycles", res_wr_cnt, 1);
        check("dirty_write_addr", res_wr_addr, 16'h7F40);
        check("dirty_write_data", res_wr_data, {8{24'hDA7A00, 8'd1}});
        check("dirty_read_addr", res_rd_addr, 16'h3440);
        check("dirty_way", res_way, 1);
        check("dirty_index", res_idx, 2);
        check("dirty_tag", res_tag, 8'h34);
        check("dirty_data", res_data, line_b);

        // Partially valid set, everything dirty.
        run_miss(16'h5660, 2'd0, 4'b1011, 4'b1111, 1, line_c, 0, 0);
`ifdef L1_INVALID_FIRST_EN
        check("inv_way", res_way, 2);
        check("inv_no_write", res_wr_cnt, 0);
        check("inv_cycles", res_cycles, 3);
`else
        check("inv_way", res_way, 0);
        check("inv_write_cycles", res_wr_cnt, 1);
        check("inv_write_addr", res_wr_addr, 16'hA060);
        check("inv_cycles", res_cycles, 4);
`endif
        check("inv_index", res_idx, 3);
        check("inv_tag", res_tag, 8'h56);

        // Stray mem_resp in IDLE.
        @(negedge clk);
        mem_resp = 1'b1;
        @(negedge clk);
        mem_resp = 1'b0;
        check("idle_resp_busy", busy, 0);
        check("idle_resp_read", mem_read, 0);

        // Stray mem_resp in SELECT, miss_req toggling during FILL.
        evict_before = evict_cnt;
        run_miss(16'h0820, 2'd3, 4'b1111, 4'b0000, 3, line_d, 1, 1);
        check("stray_cycles", res_cycles, 5);
        check("stray_read_cycles", res_rd_cnt, 3);
        check("stray_read_addr", res_rd_addr, 16'h0820);
        check("stray_way", res_way, 3);
        check("stray_data", res_data, line_d);
        repeat (4) @(negedge clk);
        check("stray_one_done", evict_cnt - evict_before, 1);
        check("stray_idle_after", busy, 0);

        // Reset while a writeback is outstanding.
        fill_before = fill_cnt;
        saw_wb = 0;
        @(negedge clk);
        miss_addr = 16'hBEE0; lru_way = 2'd3; valid_vec = 4'b1111; dirty_vec = 4'b1000;
        miss_req = 1'b1;
        for (int n = 0; n < 10 && !saw_wb; n++) begin
            @(negedge clk);
            if (mem_write) saw_wb = 1;
        end
        check("rstwb_reached", saw_wb, 1);
        check("rstwb_addr", mem_address, 16'hBEE0);
        miss_req = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rstwb_write_clear", mem_write, 0);
        check("rstwb_busy_clear", busy, 0);
        check("rstwb_sel_clear", sel_way, 0);
        check("rstwb_addr_clear", mem_address, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("rstwb_no_fill", fill_cnt - fill_before, 0);
        check("rstwb_idle", busy, 0);

        // Back-to-back clean misses, miss_req held, memory answers at once.
        n_done = 0;
        cyc = 0;
        miss_addr = 16'h1000; lru_way = 2'd0; valid_vec = 4'b1111; dirty_vec = 4'b0000;
        miss_req = 1'b1;
        for (int n = 1; n <= 40 && n_done < 3; n++) begin
            @(negedge clk);
            cyc = n;
            mem_resp = mem_read | mem_write;
            if (evict_done) begin
                t_done[n_done] = n;
                n_done++;
                if (n_done == 3) miss_req = 1'b0;
            end
        end
        mem_resp = 1'b0;
        miss_req = 1'b0;
        check("b2b_count", n_done, 3);
        check("b2b_gap1", t_done[1] - t_done[0], 4);
        check("b2b_gap2", t_done[2] - t_done[1], 4);
        repeat (3) @(negedge clk);
        check("b2b_idle_after", busy, 0);
        check("rw_exclusive", both_seen, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
